// File: rtl/binary_incrementer.sv
// Conditional +1 stage: ripple chain of half adders with y as the LSB carry-in,
// registered so {Cout,z} holds A+y one clock after the operands are sampled.

module binary_incrementer_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module binary_incrementer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic             y,
    output logic [WIDTH-1:0] z,
    output logic             Cout
);
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    // Each stage owns its carry signals so the ripple is a chain of distinct
    // nets rather than one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : stage
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = y;
        end else begin : g_rest
            assign ci = stage[i-1].co;
        end
        binary_incrementer_ha u_ha (
            .a (A[i]),
            .b (ci),
            .s (sum[i]),
            .c (co)
        );
    end

    assign carry_out = stage[WIDTH-1].co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z    <= '0;
            Cout <= 1'b0;
        end else begin
            z    <= sum;
            Cout <= carry_out;
        end
    end
endmodule

// File: tb/tb_binary_incrementer.sv
// Bench for binary_incrementer at WIDTH=4 and WIDTH=8: directed vectors feed a
// scoreboard queue, a monitor pops and compares one cycle after each issue.

module tb_binary_incrementer;
    logic       clk;
    logic       rst_n;
    logic [3:0] a4;
    logic       y4;
    logic [3:0] z4;
    logic       cout4;
    logic [7:0] a8;
    logic       y8;
    logic [7:0] z8;
    logic       cout8;

    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];
    logic       issued4, issued8;
    logic       val4, val8;
    int         checks, errors;

    binary_incrementer #(.WIDTH(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .A (a4), .y (y4), .z (z4), .Cout (cout4)
    );

    binary_incrementer #(.WIDTH(8)) dut8 (
        .clk (clk), .rst_n (rst_n), .A (a8), .y (y8), .z (z8), .Cout (cout8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks: inputs change on the falling edge, expected result queued
    task automatic drive4(input logic [3:0] a, input logic yy, input logic [4:0] exp);
        @(negedge clk);
        a4 = a; y4 = yy; issued4 = 1'b1; issued8 = 1'b0;
        exp4_q.push_back(exp);
    endtask

    task automatic drive8(input logic [7:0] a, input logic yy, input logic [8:0] exp);
        @(negedge clk);
        a8 = a; y8 = yy; issued8 = 1'b1; issued4 = 1'b0;
        exp8_q.push_back(exp);
    endtask

    task automatic idle();
        @(negedge clk);
        issued4 = 1'b0; issued8 = 1'b0;
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (z4 !== 4'b0000 || cout4 !== 1'b0 || z8 !== 8'h00 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got z4=%b cout4=%b z8=%h cout8=%b, need all zero",
                     name, z4, cout4, z8, cout8);
        end
    endtask

    // scoreboard monitor: an issue at negedge is registered at the next posedge
    always @(posedge clk) begin
        val4 <= issued4 && rst_n;
        val8 <= issued8 && rst_n;
    end

    always @(negedge clk) begin
        if (val4 && rst_n) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL w4_underflow: got {cout,z}=%b with nothing expected", {cout4, z4});
            end else begin
                logic [4:0] e;
                e = exp4_q.pop_front();
                if ({cout4, z4} !== e) begin
                    errors++;
                    $display("FAIL w4_result: got {cout,z}=%b, need %b", {cout4, z4}, e);
                end
            end
        end
        if (val8 && rst_n) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++;
                $display("FAIL w8_underflow: got {cout,z}=%h with nothing expected", {cout8, z8});
            end else begin
                logic [8:0] e;
                e = exp8_q.pop_front();
                if ({cout8, z8} !== e) begin
                    errors++;
                    $display("FAIL w8_result: got {cout,z}=%h, need %h", {cout8, z8}, e);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        issued4 = 1'b0; issued8 = 1'b0;
        a4 = 4'b1010; y4 = 1'b1;
        a8 = 8'h00;   y8 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_cleared("reset_async");

        // reset held with clk toggling and live inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cleared("reset_held");
        end

        // release and load A=1010, y=1 on the first edge
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b1010; y4 = 1'b1; issued4 = 1'b1;
        exp4_q.push_back(5'b0_1011);

        drive4(4'b0110, 1'b1, 5'b0_0111);
        drive4(4'b1001, 1'b0, 5'b0_1001);
        drive4(4'b1111, 1'b0, 5'b0_1111);
        drive4(4'b1111, 1'b1, 5'b1_0000);
        drive4(4'b0000, 1'b1, 5'b0_0001);

        // back-to-back sweep: carry-out only on 15+1
        for (int i = 0; i < 16; i++)
            drive4(4'(i), 1'b1, (i == 15) ? 5'b1_0000 : 5'(i + 1));

        // all 32 {A,y} combinations against the unsigned sum
        for (int i = 0; i < 32; i++)
            drive4(4'(i >> 1), i[0], 5'(i >> 1) + 5'(i[0]));

        drive8(8'hFF, 1'b1, 9'h100);
        drive8(8'hFF, 1'b0, 9'h0FF);
        drive8(8'h00, 1'b1, 9'h001);
        drive8(8'h7F, 1'b1, 9'h080);
        drive8(8'hA5, 1'b0, 9'h0A5);
        drive8(8'h0F, 1'b1, 9'h010);
        drive8(8'hFE, 1'b1, 9'h0FF);
        idle();
        idle();

        // reset mid-operation: the result just registered is discarded
        drive4(4'b0011, 1'b1, 5'b0_0100);
        drive4(4'b0100, 1'b1, 5'b0_0101);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("reset_mid");
        exp4_q.delete();
        exp8_q.delete();
        issued4 = 1'b0; issued8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_cleared("reset_mid_held");
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive4(4'b1001, 1'b1, 5'b0_1010);
        drive8(8'h80, 1'b1, 9'h081);
        idle();

        // bounded drain of anything still expected
        for (int i = 0; i < 10 && (exp4_q.size() != 0 || exp8_q.size() != 0); i++)
            @(negedge clk);
        checks++;
        if (exp4_q.size() != 0 || exp8_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d results outstanding, need 0/0",
                     exp4_q.size(), exp8_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
